// File: rtl/serial_addsub_if.sv
// ---------------------------------------------------------------------------
// serial_addsub_if
//   Operand/result handshake bundle for the digit-serial adder/subtractor.
//   Ports (signals):
//     in_valid / in_ready   operand handshake (producer -> block)
//     a, b, sub             operands and operation select (1 = a - b)
//     out_valid / out_ready result handshake (block -> consumer)
//     result                sum or difference, modulo 2^WIDTH
//     cout, overflow, zero  status flags accompanying result
//   Modports:
//     master  producer/consumer side (drives operands, out_ready)
//     slave   the arithmetic block
// ---------------------------------------------------------------------------
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero
  );

endinterface

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//   Digit-serial two's-complement adder/subtractor. Adds DIGIT bits per
//   cycle, LSB digit first, with the carry held in a register between digits.
//   Subtraction is a + ~b + 1 (inverted b, carry-in 1).
//   Ports:
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     bus     serial_addsub_if.slave: operand handshake, result handshake,
//             result and cout/overflow/zero flags (all outputs registered)
//   Parameters:
//     WIDTH   operand/result width (>= 2)
//     DIGIT   bits per cycle (1..WIDTH, divides WIDTH)
// ---------------------------------------------------------------------------
module serial_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_addsub_if.slave       bus
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = $clog2(NDIG + 1);
  localparam int unsigned DW   = DIGIT + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;

  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic [DW-1:0]    w_sum;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic             w_c_msb;
  logic             w_last;

  // Current digit slice, its sum, and the shadow with this digit merged in.
  always_comb begin
    w_da         = DIGIT'(r_a >> (int'(r_cnt) * DIGIT));
    w_db         = DIGIT'(r_b >> (int'(r_cnt) * DIGIT));
    w_sum        = {1'b0, w_da} + {1'b0, w_db} + DW'(r_carry);
    // Shadow is cleared on accept, so OR-ing the new digit in is sufficient.
    w_shadow_nxt = r_shadow | (WIDTH'(w_sum[DIGIT-1:0]) << (int'(r_cnt) * DIGIT));
    // Carry into the operand MSB recovered from the MSB's own sum bit.
    w_c_msb      = w_da[DIGIT-1] ^ w_db[DIGIT-1] ^ w_sum[DIGIT-1];
    w_last       = (r_cnt == CW'(NDIG - 1));
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_shadow    <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cout      <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_a        <= bus.a;
            r_b        <= bus.sub ? ~bus.b : bus.b;
            r_carry    <= bus.sub;
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_shadow <= w_shadow_nxt;
          r_carry  <= w_sum[DIGIT];
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_result    <= w_shadow_nxt;
            r_cout      <= w_sum[DIGIT];
            r_overflow  <= w_c_msb ^ w_sum[DIGIT];
            r_zero      <= (w_shadow_nxt == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // in_ready stays low here, so no accept can coincide with out_ready.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;
  assign bus.overflow  = r_overflow;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//   Directed and random checks of serial_addsub at WIDTH=16 for DIGIT=4
//   (instance 0), DIGIT=1 (instance 1) and DIGIT=16 (instance 2).
// ---------------------------------------------------------------------------
module tb_serial_addsub;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic         drv_valid [3];
  logic [W-1:0] drv_a     [3];
  logic [W-1:0] drv_b     [3];
  logic         drv_sub   [3];
  logic         drv_ordy  [3];

  logic         mon_ovalid[3];
  logic         mon_irdy  [3];
  logic [W-1:0] mon_res   [3];
  logic         mon_cout  [3];
  logic         mon_ovf   [3];
  logic         mon_zero  [3];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    serial_addsub_if #(.WIDTH(W)) u_if ();

    serial_addsub #(
      .WIDTH(W),
      .DIGIT((g == 0) ? 4 : ((g == 1) ? 1 : 16))
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (u_if)
    );

    assign u_if.in_valid  = drv_valid[g];
    assign u_if.a         = drv_a[g];
    assign u_if.b         = drv_b[g];
    assign u_if.sub       = drv_sub[g];
    assign u_if.out_ready = drv_ordy[g];

    assign mon_ovalid[g] = u_if.out_valid;
    assign mon_irdy[g]   = u_if.in_ready;
    assign mon_res[g]    = u_if.result;
    assign mon_cout[g]   = u_if.cout;
    assign mon_ovf[g]    = u_if.overflow;
    assign mon_zero[g]   = u_if.zero;
  end

  function automatic int ndig(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 16 : 1);
  endfunction

  // Reference: {result, cout, overflow, zero}.
  function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic ms);
    logic [16:0] full;
    logic [15:0] r;
    logic        ov;
    if (ms) full = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
    else    full = {1'b0, ma} + {1'b0, mb};
    r  = full[15:0];
    if (ms) ov = (ma[15] != mb[15]) && (r[15] != ma[15]);
    else    ov = (ma[15] == mb[15]) && (r[15] != ma[15]);
    return {r, full[16], ov, (r == 16'h0000)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands and return just after the accepting edge.
  task automatic send(input int i, input logic [15:0] ta, input logic [15:0] tb_,
                      input logic ts);
    int n;
    n = 0;
    @(negedge clk);
    drv_valid[i] = 1'b1;
    drv_a[i]     = ta;
    drv_b[i]     = tb_;
    drv_sub[i]   = ts;
    while (!mon_irdy[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    drv_valid[i] = 1'b0;
  endtask

  // Count clock edges from the accepting edge until out_valid is seen.
  task automatic wait_out(input int i, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (mon_ovalid[i]) break;
      lat++;
      if (lat > 100) begin
        check("out_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic run_op(input int i, input string tag, input logic [15:0] ta,
                        input logic [15:0] tb_, input logic ts, input logic [15:0] er,
                        input logic ec, input logic eo, input logic ez);
    int lat;
    send(i, ta, tb_, ts);
    wait_out(i, lat);
    check({tag, "_lat"},  lat,          ndig(i));
    check({tag, "_res"},  mon_res[i],   er);
    check({tag, "_cout"}, mon_cout[i],  ec);
    check({tag, "_ovf"},  mon_ovf[i],   eo);
    check({tag, "_zero"}, mon_zero[i],  ez);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    logic [15:0] ra, rb;
    logic        rs;
    logic [18:0] e;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv_valid[i] = 1'b0;
      drv_a[i]     = '0;
      drv_b[i]     = '0;
      drv_sub[i]   = 1'b0;
      drv_ordy[i]  = 1'b1;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_irdy",   mon_irdy[0],   1'b1);
    check("rst_ovalid", mon_ovalid[0], 1'b0);
    check("rst_res",    mon_res[0],    16'h0000);
    check("rst_flags",  {mon_cout[0], mon_ovf[0], mon_zero[0]}, 3'b000);
    rst_n = 1'b1;

    // Directed arithmetic at DIGIT=4
    run_op(0, "add_1234",  16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op(0, "sub_5m7",   16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op(0, "sub_8000",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op(0, "add_wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(0, "sub_eq",    16'h5A5A, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(0, "add_povf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

    // Digit-size extremes
    run_op(1, "d1_add",    16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op(1, "d1_sub",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op(2, "d16_add",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(2, "d16_sub",   16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // Backpressure: result held while a new op waits
    drv_ordy[0] = 1'b0;
    send(0, 16'h0100, 16'h0001, 1'b0);
    wait_out(0, lat);
    check("bp_lat", lat, 32'd4);
    drv_valid[0] = 1'b1;
    drv_a[0]     = 16'h0002;
    drv_b[0]     = 16'h0003;
    drv_sub[0]   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("bp_hold_res",    mon_res[0],    16'h0101);
      check("bp_hold_irdy",   mon_irdy[0],   1'b0);
      check("bp_hold_ovalid", mon_ovalid[0], 1'b1);
      @(negedge clk);
    end
    drv_ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_irdy",   mon_irdy[0],   1'b1);
    check("bp_idle_ovalid", mon_ovalid[0], 1'b0);
    check("bp_idle_res",    mon_res[0],    16'h0101);
    @(posedge clk);
    #1;
    drv_valid[0] = 1'b0;
    wait_out(0, lat);
    check("bp2_lat",   lat,         32'd4);
    check("bp2_res",   mon_res[0],  16'hFFFF);
    check("bp2_flags", {mon_cout[0], mon_ovf[0], mon_zero[0]}, 3'b000);
    @(posedge clk);
    #1;

    // Reset during the second BUSY cycle
    send(0, 16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ar_ovalid", mon_ovalid[0], 1'b0);
    check("ar_res",    mon_res[0],    16'h0000);
    check("ar_flags",  {mon_cout[0], mon_ovf[0], mon_zero[0]}, 3'b000);
    check("ar_irdy",   mon_irdy[0],   1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("ar_no_pulse", mon_ovalid[0], 1'b0);
      check("ar_rel_irdy", mon_irdy[0],   1'b1);
    end
    run_op(0, "after_rst", 16'h0003, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);

    // Random operations against the reference model
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < ((i == 1) ? 150 : 300); n++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rs = 1'($urandom_range(0, 1));
        e  = model(ra, rb, rs);
        run_op(i, "rnd", ra, rb, rs, e[18:3], e[2], e[1], e[0]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
